// File: rtl/input_debouncer.sv
// input_debouncer: synchronises and debounces the raw board buttons and slide
// switches against a shared sample tick, and publishes stable levels plus
// single-cycle edge pulses.
//
// Ports:
//   clk          board clock, all state on the rising edge
//   rstn         asynchronous active-low reset
//   btn_i        raw push-buttons (asynchronous to clk)
//   sw_i         raw slide switches (asynchronous to clk)
//   BTN_out      debounced button levels
//   SW_out       debounced switch levels
//   btn_press    one-cycle pulse per bit on a debounced 0->1 button edge
//   btn_release  one-cycle pulse per bit on a debounced 1->0 button edge
//   sw_change    one-cycle pulse per bit on any debounced switch edge
//   tick_o       sample-tick strobe
module input_debouncer #(
    parameter int unsigned N_BTN        = 5,
    parameter int unsigned N_SW         = 16,
    parameter int unsigned TICK_DIV     = 100000,
    parameter int unsigned STABLE_TICKS = 5
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [N_BTN-1:0] btn_i,
    input  logic [N_SW-1:0]  sw_i,
    output logic [N_BTN-1:0] BTN_out,
    output logic [N_SW-1:0]  SW_out,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_release,
    output logic [N_SW-1:0]  sw_change,
    output logic             tick_o
);

    localparam int unsigned N_IN = N_BTN + N_SW;
    localparam int unsigned PW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned CW   = $clog2(STABLE_TICKS + 1);

    // Buttons occupy the low bits, switches the high bits of the shared vector.
    logic [N_IN-1:0] w_raw;
    assign w_raw = {sw_i, btn_i};

    logic [N_IN-1:0] r_sync1;
    logic [N_IN-1:0] r_sync2;
    logic [N_IN-1:0] r_stable;
    logic [CW-1:0]   r_cnt [N_IN];
    logic [PW-1:0]   r_presc;
    logic            r_tick;
    logic [N_BTN-1:0] r_press;
    logic [N_BTN-1:0] r_release;
    logic [N_SW-1:0]  r_change;

    logic [N_IN-1:0] w_stable_nxt;
    logic [CW-1:0]   w_cnt_nxt [N_IN];
    logic [N_IN-1:0] w_accept;
    logic [N_IN-1:0] w_rise;
    logic [N_IN-1:0] w_fall;

    // Two-flop synchroniser per input bit.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= w_raw;
            r_sync2 <= r_sync1;
        end
    end

    // Free-running prescaler; the tick register is armed one count early so
    // it is high exactly while the counter sits at TICK_DIV-1.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_presc <= '0;
            r_tick  <= 1'b0;
        end else begin
            if (r_presc == PW'(TICK_DIV - 1)) begin
                r_presc <= '0;
            end else begin
                r_presc <= r_presc + PW'(1);
            end
            r_tick <= (r_presc == PW'(TICK_DIV - 2));
        end
    end

    // Per-bit debounce decision, only evaluated on tick cycles.
    always_comb begin
        w_stable_nxt = r_stable;
        w_cnt_nxt    = r_cnt;
        w_accept     = '0;
        if (r_tick) begin
            for (int i = 0; i < int'(N_IN); i++) begin
                if (r_sync2[i] == r_stable[i]) begin
                    w_cnt_nxt[i] = '0;
                end else if (r_cnt[i] == CW'(STABLE_TICKS - 1)) begin
                    w_stable_nxt[i] = r_sync2[i];
                    w_cnt_nxt[i]    = '0;
                    w_accept[i]     = 1'b1;
                end else begin
                    w_cnt_nxt[i] = r_cnt[i] + CW'(1);
                end
            end
        end
    end

    assign w_rise = w_accept & r_sync2;
    assign w_fall = w_accept & ~r_sync2;

    // Stable levels, counters and edge pulses all update on the same edge,
    // so a pulse coincides with the first cycle of the new level.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_stable  <= '0;
            r_press   <= '0;
            r_release <= '0;
            r_change  <= '0;
            for (int i = 0; i < int'(N_IN); i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            r_stable  <= w_stable_nxt;
            r_press   <= w_rise[N_BTN-1:0];
            r_release <= w_fall[N_BTN-1:0];
            r_change  <= w_accept[N_IN-1:N_BTN];
            for (int i = 0; i < int'(N_IN); i++) begin
                r_cnt[i] <= w_cnt_nxt[i];
            end
        end
    end

    assign BTN_out     = r_stable[N_BTN-1:0];
    assign SW_out      = r_stable[N_IN-1:N_BTN];
    assign btn_press   = r_press;
    assign btn_release = r_release;
    assign sw_change   = r_change;
    assign tick_o      = r_tick;

endmodule

// File: tb/tb_input_debouncer.sv
// tb_input_debouncer: directed self-checking bench for input_debouncer with
// TICK_DIV=4 and STABLE_TICKS=3. Outputs are sampled on the falling edge.
module tb_input_debouncer;

    logic        clk;
    logic        rstn;
    logic [4:0]  btn_i;
    logic [15:0] sw_i;
    logic [4:0]  BTN_out;
    logic [15:0] SW_out;
    logic [4:0]  btn_press;
    logic [4:0]  btn_release;
    logic [15:0] sw_change;
    logic        tick_o;

    int n_checks;
    int n_errors;

    input_debouncer #(
        .N_BTN       (5),
        .N_SW        (16),
        .TICK_DIV    (4),
        .STABLE_TICKS(3)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .btn_i      (btn_i),
        .sw_i       (sw_i),
        .BTN_out    (BTN_out),
        .SW_out     (SW_out),
        .btn_press  (btn_press),
        .btn_release(btn_release),
        .sw_change  (sw_change),
        .tick_o     (tick_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reset with quiet inputs; rstn rises on a falling edge.
    task automatic quiet_reset();
        btn_i = '0;
        sw_i  = '0;
        rstn  = 1'b0;
        step();
        step();
        rstn  = 1'b1;
    endtask

    // Waits for BTN_out to reach lvl; checks the pulses on that cycle and
    // that they clear on the following one. lat is 0 on timeout.
    task automatic measure(input string tag, input logic [4:0] lvl,
                           input logic [4:0] prs, input logic [4:0] rel,
                           output int lat);
        lat = 0;
        for (int i = 1; i <= 20; i++) begin
            step();
            if (lat == 0 && BTN_out === lvl) begin
                lat = i;
                chk({tag, "_press"},   32'(btn_press),   32'(prs));
                chk({tag, "_release"}, 32'(btn_release), 32'(rel));
            end else if (lat != 0) begin
                chk({tag, "_press_clr"},   32'(btn_press),   32'd0);
                chk({tag, "_release_clr"}, 32'(btn_release), 32'd0);
                chk({tag, "_hold"},        32'(BTN_out),     32'(lvl));
                break;
            end
        end
    endtask

    initial begin
        int first;
        int lat;
        int sw_trans;
        int sw_pulses;
        logic [15:0] prev_sw;

        n_checks = 0;
        n_errors = 0;

        // Reset with inputs already high.
        rstn  = 1'b0;
        btn_i = 5'h1F;
        sw_i  = 16'hA5A5;
        step(); step(); step();
        chk("rst_btn",     32'(BTN_out),     32'd0);
        chk("rst_sw",      32'(SW_out),      32'd0);
        chk("rst_press",   32'(btn_press),   32'd0);
        chk("rst_release", 32'(btn_release), 32'd0);
        chk("rst_change",  32'(sw_change),   32'd0);
        chk("rst_tick",    32'(tick_o),      32'd0);

        // Startup acceptance: tick after edges 3,7,11; accept on edge 12.
        rstn  = 1'b1;
        first = 0;
        for (int i = 1; i <= 14; i++) begin
            step();
            chk("tick_phase", 32'(tick_o), ((i % 4) == 3) ? 32'd1 : 32'd0);
            if (first == 0 && BTN_out != 5'h0) begin
                first = i;
                chk("start_btn",   32'(BTN_out),   32'h1F);
                chk("start_sw",    32'(SW_out),    32'hA5A5);
                chk("start_press", 32'(btn_press), 32'h1F);
                chk("start_chg",   32'(sw_change), 32'hA5A5);
            end else if (first != 0 && i == first + 1) begin
                chk("start_press_clr", 32'(btn_press), 32'd0);
                chk("start_chg_clr",   32'(sw_change), 32'd0);
            end
        end
        chk("start_latency", 32'((first >= 1 && first <= 14) ? 1 : 0), 32'd1);

        // Glitch of 7 cycles on btn 0 must be rejected.
        quiet_reset();
        btn_i[0] = 1'b1;
        for (int i = 0; i < 27; i++) begin
            step();
            if (i == 6) btn_i[0] = 1'b0;
            chk("glitch_btn",     32'(BTN_out),     32'd0);
            chk("glitch_press",   32'(btn_press),   32'd0);
            chk("glitch_release", 32'(btn_release), 32'd0);
        end

        // Clean press and release on btn 2.
        btn_i[2] = 1'b1;
        measure("press2", 5'b00100, 5'b00100, 5'b00000, lat);
        chk("press2_lat", 32'((lat >= 11 && lat <= 14) ? 1 : 0), 32'd1);
        btn_i[2] = 1'b0;
        measure("rel2", 5'b00000, 5'b00000, 5'b00100, lat);
        chk("rel2_lat", 32'((lat >= 11 && lat <= 14) ? 1 : 0), 32'd1);

        // Bouncing switch 15 toggling every 3 cycles, then settling high.
        sw_trans  = 0;
        sw_pulses = 0;
        prev_sw   = SW_out;
        sw_i[15]  = 1'b1;
        for (int k = 0; k < 50; k++) begin
            step();
            if (SW_out != prev_sw) sw_trans++;
            if (sw_change != 16'h0) begin
                sw_pulses++;
                chk("bounce_pulse_align", 32'((SW_out != prev_sw) ? 1 : 0), 32'd1);
            end
            prev_sw = SW_out;
            if (k < 30 && (k % 3) == 2) sw_i[15] = ~sw_i[15];
            if (k == 29) sw_i[15] = 1'b1;
        end
        chk("bounce_trans",  32'(sw_trans),  32'd1);
        chk("bounce_pulses", 32'(sw_pulses), 32'd1);
        chk("bounce_level",  32'(SW_out),    32'h8000);

        // Simultaneous press on btn 0 and btn 4.
        btn_i = 5'b10001;
        measure("simul", 5'b10001, 5'b10001, 5'b00000, lat);
        chk("simul_lat", 32'((lat >= 11 && lat <= 14) ? 1 : 0), 32'd1);

        // Asynchronous reset two ticks into a press of btn 1.
        btn_i[1] = 1'b1;
        for (int i = 0; i < 8; i++) step();
        chk("pre_areset_btn", 32'(BTN_out), 32'b10001);
        #1 rstn = 1'b0;
        #1;
        chk("areset_btn",  32'(BTN_out),   32'd0);
        chk("areset_sw",   32'(SW_out),    32'd0);
        chk("areset_prs",  32'(btn_press), 32'd0);
        chk("areset_tick", 32'(tick_o),    32'd0);
        step();
        step();
        rstn = 1'b1;
        for (int i = 1; i <= 13; i++) begin
            step();
            if (i < 12) begin
                chk("rearm_wait_btn", 32'(BTN_out), 32'd0);
            end else if (i == 12) begin
                chk("rearm_btn",   32'(BTN_out),   32'b10011);
                chk("rearm_press", 32'(btn_press), 32'b10011);
                chk("rearm_sw",    32'(SW_out),    32'h8000);
            end else begin
                chk("rearm_press_clr", 32'(btn_press), 32'd0);
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/input_debouncer.md
Name: input_debouncer

Overview:
Conditions the raw board inputs (5 push-buttons, 16 slide switches) before they reach the MIO bus and the clock divider switch taps. Each bit is synchronised into the system clock domain and debounced against a shared sample tick. The block publishes stable levels on BTN_out/SW_out and single-cycle edge pulses for software-visible button events. It sits between the board pins and the bus/peripheral logic, on the board clock.

Parameters:
N_BTN, 5, number of button inputs
N_SW, 16, number of switch inputs
TICK_DIV, 100000, clk cycles per sample tick (1 ms at 100 MHz); legal range >= 2
STABLE_TICKS, 5, consecutive ticks a new level must persist before acceptance; legal range 1..15

Ports:
clk  input  1  board clock; all state on rising edge
rstn  input  1  reset, asynchronous, active-low
btn_i  input  N_BTN  raw buttons, asynchronous to clk
sw_i  input  N_SW  raw switches, asynchronous to clk
BTN_out  output  N_BTN  debounced button levels
SW_out  output  N_SW  debounced switch levels
btn_press  output  N_BTN  one-cycle pulse per bit on debounced 0->1
btn_release  output  N_BTN  one-cycle pulse per bit on debounced 1->0
sw_change  output  N_SW  one-cycle pulse per bit on any debounced switch transition
tick_o  output  1  sample-tick strobe, for bench visibility

Behaviour:
- Reset: rstn low asynchronously clears all flops. BTN_out, SW_out, btn_press, btn_release, sw_change, tick_o = 0. Synchroniser stages, prescaler and per-bit counters = 0.
- Synchroniser: 2-flop chain per bit. A raw change is visible at sync output 2 cycles later.
- Prescaler: counter runs 0..TICK_DIV-1 and wraps to 0. tick_o = 1 for exactly one cycle, when the counter equals TICK_DIV-1. The prescaler is free-running and is never restarted by input activity.
- Per-bit debounce, evaluated only on tick cycles:
  - If sync == stable, cnt <= 0.
  - If sync != stable and cnt == STABLE_TICKS-1, stable <= sync and cnt <= 0.
  - Otherwise cnt <= cnt+1.
  - On non-tick cycles, cnt and stable hold.
  - Counter width = clog2(STABLE_TICKS+1). It never exceeds STABLE_TICKS-1.
- Glitch rule: a deviation that returns to the stable level before STABLE_TICKS consecutive deviating samples resets cnt. Its partial count is discarded, and it produces no output change and no pulse.
- Latency: after a clean raw change, the output updates 2 + (STABLE_TICKS-1)*TICK_DIV + 1 to 2 + STABLE_TICKS*TICK_DIV cycles later.
- Edge pulses:
  - Registered on the same edge as the stable update, so a pulse is high in the first cycle the new level appears on BTN_out/SW_out.
  - Width is exactly 1 cycle.
  - Bits are independent. Simultaneous accepts on several bits pulse in the same cycle.
- Startup: inputs already high at reset release are treated as transitions from 0. They produce press/change pulses once accepted.
- Reset mid-operation: all partial counts are lost and any pulse in flight is dropped. Debouncing restarts from zero state after rstn rises.
- No handshake: consumers sample levels or pulses directly. Pulses are not held if the consumer misses them.

Test Plan:
- Bench params for all scenarios: TICK_DIV=4, STABLE_TICKS=3.
- Reset/startup: btn_i=5'h1F and sw_i=16'hA5A5 held through reset -> all outputs 0 while rstn=0. Within 14 cycles of rstn rising, BTN_out=5'h1F and SW_out=16'hA5A5, with btn_press=5'h1F and sw_change=16'hA5A5 high for exactly 1 cycle, in the same cycle the levels appear.
- Glitch rejection: btn_i[0]=1 for 7 cycles, then 0 -> BTN_out[0] stays 0, and btn_press/btn_release stay 0 throughout.
- Clean press/release: btn_i[2] rises and holds -> BTN_out[2]=1 between 11 and 14 cycles later, with btn_press=5'b00100 for 1 cycle. Drop btn_i[2] -> btn_release=5'b00100 for 1 cycle, after the same latency bounds.
- Bounce then settle: sw_i[15] toggles every 3 cycles for 30 cycles, then holds 1 -> SW_out settles at 16'h8000 with exactly one sw_change[15] pulse and no intermediate SW_out toggles.
- Simultaneous events: btn_i[0] and btn_i[4] rise in the same cycle -> btn_press=5'b10001 in a single cycle.
- Async reset mid-count: assert rstn low 2 ticks into a press -> outputs clear immediately, without waiting for clk. After release, the press is re-accepted only after the full startup latency.
